// File: rtl/signal_checker.sv
// -----------------------------------------------------------------------------
// signal_checker
//
// Avalon-ST sink that verifies an incrementing-count stream: every accepted
// beat must equal the previously accepted beat plus one (modulo 2^DATA_WIDTH).
// Accepted beats, sequence mismatches and beats carrying a non-zero error
// field are counted in saturating counters, readable through a small
// Avalon-MM CSR slave with a fixed read latency of one cycle.
//
// Optional build macro: SIGNAL_CHECKER_BACKPRESSURE_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1)
//   drives pseudo-random backpressure on the sink ready while enabled.
//   When undefined, ready is held at 1 whenever the checker is enabled.
//
// Ports:
//   clk                     in   single clock for all logic
//   reset_n                 in   asynchronous active-low reset
//   avalonst_sink_valid     in   stream beat valid
//   avalonst_sink_data      in   stream data [DATA_WIDTH]
//   avalonst_sink_error     in   stream error field [ERROR_WIDTH]
//   avalonst_sink_ready     out  registered sink ready (readyLatency 0)
//   avalonmm_csr_address    in   CSR word address [3]
//   avalonmm_csr_read       in   CSR read strobe
//   avalonmm_csr_readdata   out  CSR read data [32], valid one cycle after read
//   avalonmm_csr_write      in   CSR write strobe
//   avalonmm_csr_writedata  in   CSR write data [32]
//
// CSR map: 0 CTRL {clear(W1), enable}, 1 STATUS {errflag, mismatch, locked},
//          2 BEAT_CNT, 3 MIS_CNT, 4 ERR_CNT, 5 LAST_EXP, 6 LAST_RCV, 7 zero.
// -----------------------------------------------------------------------------
module signal_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int ERROR_WIDTH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   avalonst_sink_valid,
  input  logic [DATA_WIDTH-1:0]  avalonst_sink_data,
  input  logic [ERROR_WIDTH-1:0] avalonst_sink_error,
  output logic                   avalonst_sink_ready,
  input  logic [2:0]             avalonmm_csr_address,
  input  logic                   avalonmm_csr_read,
  output logic [31:0]            avalonmm_csr_readdata,
  input  logic                   avalonmm_csr_write,
  input  logic [31:0]            avalonmm_csr_writedata
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_ready;
  logic                   r_enable;
  logic [DATA_WIDTH-1:0]  r_expected;
  logic [CNT_WIDTH-1:0]   r_beatCnt;
  logic [CNT_WIDTH-1:0]   r_misCnt;
  logic [CNT_WIDTH-1:0]   r_errCnt;
  logic [DATA_WIDTH-1:0]  r_lastExp;
  logic [DATA_WIDTH-1:0]  r_lastRcv;
  logic                   r_stickyMis;
  logic                   r_stickyErr;
  logic [31:0]            r_readdata;

  logic w_accept;
  logic w_wrCtrl;
  logic w_clear;
  logic w_enNext;
  logic w_beat;
  logic w_mismatch;
  logic w_errBeat;
  logic w_locked;
  logic w_readyGate;
  logic w_unusedWriteBits;

  // A clear in the same cycle as an accepted beat discards that beat.
  assign w_accept   = avalonst_sink_valid && r_ready;
  assign w_wrCtrl   = avalonmm_csr_write && (avalonmm_csr_address == 3'd0);
  assign w_clear    = w_wrCtrl && avalonmm_csr_writedata[1];
  assign w_enNext   = w_wrCtrl ? avalonmm_csr_writedata[0] : r_enable;
  assign w_beat     = w_accept && !w_clear;
  assign w_mismatch = w_beat && (r_state == ST_LOCKED) &&
                      (avalonst_sink_data != r_expected);
  assign w_errBeat  = w_beat && (|avalonst_sink_error);
  assign w_locked   = (r_state == ST_LOCKED);

  assign w_unusedWriteBits = ^avalonmm_csr_writedata[31:2];

  assign avalonst_sink_ready   = r_ready;
  assign avalonmm_csr_readdata = r_readdata;

`ifdef SIGNAL_CHECKER_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsrLoad;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; the seed is
  // reloaded on clear so backpressure patterns are repeatable per run.
  assign w_lfsrLoad = w_clear ? 16'hACE1 :
                      {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_readyGate = w_lfsrLoad[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= w_lfsrLoad;
    end
  end
`else
  assign w_readyGate = 1'b1;
`endif

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Control FSM. Ready is registered alongside the state so that it drops in
  // the very cycle the checker becomes disabled and rises as it enters SYNC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_DISABLED;
      r_ready  <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      r_enable <= w_enNext;
      if (!w_enNext) begin
        r_state <= ST_DISABLED;
        r_ready <= 1'b0;
      end else begin
        r_ready <= w_readyGate;
        if (w_clear || (r_state == ST_DISABLED)) begin
          r_state <= ST_SYNC;
        end else if ((r_state == ST_SYNC) && w_accept) begin
          r_state <= ST_LOCKED;
        end
      end
    end
  end

  // Sequence tracking and statistics. The expected value always resyncs to
  // the received beat, so a single dropped beat costs exactly one mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_expected  <= '0;
      r_beatCnt   <= '0;
      r_misCnt    <= '0;
      r_errCnt    <= '0;
      r_lastExp   <= '0;
      r_lastRcv   <= '0;
      r_stickyMis <= 1'b0;
      r_stickyErr <= 1'b0;
    end else if (w_clear) begin
      r_expected  <= '0;
      r_beatCnt   <= '0;
      r_misCnt    <= '0;
      r_errCnt    <= '0;
      r_lastExp   <= '0;
      r_lastRcv   <= '0;
      r_stickyMis <= 1'b0;
      r_stickyErr <= 1'b0;
    end else if (w_beat) begin
      r_expected <= avalonst_sink_data + DATA_WIDTH'(1);
      r_beatCnt  <= satInc(r_beatCnt);
      if (w_mismatch) begin
        r_misCnt    <= satInc(r_misCnt);
        r_stickyMis <= 1'b1;
        r_lastExp   <= r_expected;
        r_lastRcv   <= avalonst_sink_data;
      end
      if (w_errBeat) begin
        r_errCnt    <= satInc(r_errCnt);
        r_stickyErr <= 1'b1;
      end
    end
  end

  // CSR read port: registered mux sampled from current state, so a read that
  // coincides with a counter update returns the pre-update value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (avalonmm_csr_read) begin
      case (avalonmm_csr_address)
        3'd0:    r_readdata <= 32'(r_enable);
        3'd1:    r_readdata <= 32'({r_stickyErr, r_stickyMis, w_locked});
        3'd2:    r_readdata <= 32'(r_beatCnt);
        3'd3:    r_readdata <= 32'(r_misCnt);
        3'd4:    r_readdata <= 32'(r_errCnt);
        3'd5:    r_readdata <= 32'(r_lastExp);
        3'd6:    r_readdata <= 32'(r_lastRcv);
        default: r_readdata <= '0;
      endcase
    end
  end

endmodule

// File: doc/signal_checker.md
Name: signal_checker

Overview:
- Avalon-ST sink that consumes the incrementing-count stream from the team's signal generator and verifies that each accepted beat equals the previous one plus 1.
- Counts accepted beats, sequence mismatches and beats with a non-zero error field.
- Exposes control and statistics through a small Avalon-MM CSR slave.
- Sits at the far end of a streaming path as a loopback/link-integrity checker.

Parameters:
DATA_WIDTH, 32, width of stream data and the expected-value register
ERROR_WIDTH, 8, width of stream error field
CNT_WIDTH, 32, width of each statistics counter (saturating)

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
avalonst_sink_valid  in  1  stream beat valid
avalonst_sink_data  in  DATA_WIDTH  stream data
avalonst_sink_error  in  ERROR_WIDTH  stream error field
avalonst_sink_ready  out  1  sink ready (readyLatency 0)
avalonmm_csr_address  in  3  CSR word address
avalonmm_csr_read  in  1  CSR read strobe
avalonmm_csr_readdata  out  32  CSR read data, fixed read latency 1
avalonmm_csr_write  in  1  CSR write strobe
avalonmm_csr_writedata  in  32  CSR write data

Behaviour:
- Reset (async assert, sync release): state DISABLED; ready=0; readdata=0; all counters, captures and sticky bits 0; enable=0.
- Accept = valid && ready in the same cycle (readyLatency 0). The ready output is registered.
- States:
  - DISABLED: ready=0. Moves to SYNC on the cycle after enable is written to 1.
  - SYNC: ready=1. On the first accepted beat: expected<=data+1, beat_cnt++, go to LOCKED. No compare in SYNC.
  - LOCKED: ready=1. On each accept: beat_cnt++.
    - If data!=expected: mis_cnt++, sticky MISMATCH=1, LAST_EXP<=expected, LAST_RCV<=data.
    - In both cases expected<=data+1 (resync), so one dropped beat yields exactly one mismatch.
- Error field: any accepted beat with error!=0 increments err_cnt and sets sticky ERRFLAG. This applies in SYNC and LOCKED. Data comparison is unaffected.
- Arithmetic:
  - expected wraps modulo 2^DATA_WIDTH; 0xFFFFFFFF followed by 0x00000000 is not a mismatch.
  - Counters saturate at all-ones and never wrap.
- Enable cleared while SYNC/LOCKED: go to DISABLED next cycle. A beat accepted in the cycle of the write is still processed. Counters hold. Re-enable enters SYNC, never LOCKED directly.
- CLEAR (write-1 pulse, self-clearing):
  - Zeroes counters, captures and sticky bits.
  - If enabled, state goes to SYNC; otherwise it stays DISABLED.
  - A beat accepted in the same cycle is discarded; clear wins.
- CSR map (word addresses):
  - 0 CTRL: [0] enable RW, [1] clear W1 (reads 0).
  - 1 STATUS RO: [0] locked, [1] MISMATCH sticky, [2] ERRFLAG sticky.
  - 2 BEAT_CNT RO.
  - 3 MIS_CNT RO.
  - 4 ERR_CNT RO.
  - 5 LAST_EXP RO.
  - 6 LAST_RCV RO.
  - 7 reads 0.
- Writes to RO addresses are ignored. readdata is updated one cycle after read and holds until the next read. A read coinciding with a counter update returns the pre-update value.

Optional Feature:
SIGNAL_CHECKER_BACKPRESSURE_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset and on CLEAR) advances every cycle.
  - In SYNC/LOCKED, ready = registered lfsr[0], giving pseudo-random backpressure. DISABLED still forces ready=0.
- Undefined: no LFSR; ready is constantly 1 in SYNC/LOCKED.

Test Plan:
- Reset, write CTRL=1, drive data 5,6,7,8 on consecutive valid cycles -> STATUS.locked=1, BEAT_CNT=4, MIS_CNT=0, STATUS[1]=0.
- Locked stream 10,11,13,14 -> MIS_CNT=1, LAST_EXP=12, LAST_RCV=13, STATUS[1]=1, BEAT_CNT=4.
- Stream 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001 -> MIS_CNT=0.
- Beats with error=0x00,0x04,0x00 -> ERR_CNT=1, STATUS[2]=1; with a clean sequence, MIS_CNT stays 0.
- Write clear in the same cycle as an accepted beat -> BEAT_CNT=0, state SYNC, next beat 100 then 101 gives MIS_CNT=0.
- Write enable=0 mid-stream -> ready=0 the next cycle, counters frozen. Re-enable, send 50,51 -> no mismatch (resynced). Assert reset_n=0 mid-stream -> ready=0 and all CSRs 0 immediately.
